sat_accum_bs: RTL and testbench

Parametrised, handshaked saturating frame accumulator. It sums a frame of signed samples in a saturating accumulator and clips the frame total to a narrow signed output range, symmetric or two's-complement. The result is held in a registered output stage until the consumer accepts it. It sits between sample-rate datapaths and narrow-width consumers, and generalises the fixed 8→4-bit symmetric saturator to configurable widths, accumulation and flow control.

---
 rtl/sat_accum_bs_pkg.sv | 29 ++
 rtl/sat_accum_bs_if.sv | 33 +++
 rtl/sat_accum_bs_clip.sv | 34 +++
 rtl/sat_accum_bs.sv | 147 ++++++++++++++
 tb/tb_sat_accum_bs.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sat_accum_bs_pkg.sv
// ---------------------------------------------------------------------------
// sat_pkg
// Shared definitions for the saturating frame accumulator (sat_accum_bs).
//   sat_state_e : frame FSM states (IDLE, ACCUM, HOLD)
//   sat_max     : largest value representable in a w-bit clipped range
//   sat_min     : smallest value of that range; -sat_max when sym is set,
//                 otherwise the full two's-complement minimum
// ---------------------------------------------------------------------------
package sat_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } sat_state_e;

    // The positive limit is the same for both range styles; sym is taken so
    // the pair (w, sym) can be handed unchanged to sat_max and sat_min.
    function automatic longint sat_max(input int w, input bit sym);
        longint lim;
        lim = (longint'(1) <<< (w - 1)) - longint'(1);
        return sym ? lim : lim;
    endfunction

    function automatic longint sat_min(input int w, input bit sym);
        return sym ? -sat_max(w, sym) : -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/sat_accum_bs_if.sv
// ---------------------------------------------------------------------------
// sat_accum_bs_if
// Sample-in / result-out handshake bundle for sat_accum_bs.
//   in_valid/in_ready/in_data/in_last  : sample stream (producer -> block)
//   out_valid/out_ready/out_data/out_sat: frame result (block -> consumer)
//   sat_count                          : saturated-frame statistics
// Modports: master = environment side, slave = accumulator side.
// ---------------------------------------------------------------------------
interface sat_accum_bs_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4,
    parameter int CNT_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_sat;
    logic [CNT_W-1:0]        sat_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, sat_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, sat_count
    );
endinterface

// File: rtl/sat_accum_bs_clip.sv
// ---------------------------------------------------------------------------
// sat_clip
// Combinational signed clipper from IW bits down to an OW-bit range.
//   i_d    : signed input value (IW bits)
//   o_q    : value clipped to [sat_min(OW), sat_max(OW)] (OW bits)
//   o_clip : high when the input lay outside the range
// Parameters: IW, OW (OW <= IW), SYMMETRIC (1: +/-max, 0: two's complement).
// ---------------------------------------------------------------------------
module sat_clip
    import sat_pkg::*;
#(
    parameter int IW        = 13,
    parameter int OW        = 12,
    parameter bit SYMMETRIC = 1'b1
) (
    input  logic signed [IW-1:0] i_d,
    output logic signed [OW-1:0] o_q,
    output logic                 o_clip
);
    localparam logic signed [IW-1:0] MAXV = IW'(sat_max(OW, SYMMETRIC));
    localparam logic signed [IW-1:0] MINV = IW'(sat_min(OW, SYMMETRIC));

    always_comb begin
        o_q    = OW'(i_d);
        o_clip = 1'b0;
        if (i_d > MAXV) begin
            o_q    = OW'(MAXV);
            o_clip = 1'b1;
        end else if (i_d < MINV) begin
            o_q    = OW'(MINV);
            o_clip = 1'b1;
        end
    end
endmodule

// File: rtl/sat_accum_bs.sv
// ---------------------------------------------------------------------------
// sat_accum_bs
// Handshaked saturating frame accumulator. Samples of a frame are summed in a
// saturating ACC_W-bit accumulator; on the last sample the total is clipped to
// OUT_W bits and held in a registered output until the consumer takes it.
// Ports:
//   clk   : clock, rising edge
//   rst_b : synchronous active-low reset
//   sif   : sat_accum_bs_if.slave (sample stream, result stream, sat_count)
// Optional feature macro: SAT_ACCUM_STATS_EN -- when defined, sat_count counts
// accepted results flagged out_sat (wrapping); otherwise sat_count is 0.
// ---------------------------------------------------------------------------
module sat_accum_bs
    import sat_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter int OUT_W     = 4,
    parameter int ACC_W     = 12,
    parameter bit SYMMETRIC = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic           clk,
    input  logic           rst_b,
    sat_accum_bs_if.slave  sif
);
    sat_state_e              r_state;
    sat_state_e              w_state_nxt;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_flag;
    logic                    r_out_valid;
    logic signed [OUT_W-1:0] r_out_data;
    logic                    r_out_sat;

    logic                    w_in_acc;
    logic                    w_out_acc;
    logic                    w_acc_load;
    logic                    w_frame_done;
    logic signed [ACC_W:0]   w_sum;
    logic signed [ACC_W-1:0] w_acc_clipped;
    logic                    w_acc_clip;
    logic signed [OUT_W-1:0] w_out_clipped;
    logic                    w_out_clip;

    // Input stalls only while a result is waiting and the consumer refuses it.
    assign sif.in_ready = !r_out_valid || sif.out_ready;
    assign w_in_acc     = sif.in_valid && sif.in_ready;
    assign w_out_acc    = r_out_valid && sif.out_ready;

    // One guard bit above the accumulator so the sum can never wrap.
    assign w_sum = $signed({r_acc[ACC_W-1], r_acc})
                 + $signed({{(ACC_W+1-IN_W){sif.in_data[IN_W-1]}}, sif.in_data});

    sat_clip #(
        .IW        (ACC_W + 1),
        .OW        (ACC_W),
        .SYMMETRIC (SYMMETRIC)
    ) u_acc_clip (
        .i_d    (w_sum),
        .o_q    (w_acc_clipped),
        .o_clip (w_acc_clip)
    );

    sat_clip #(
        .IW        (ACC_W),
        .OW        (OUT_W),
        .SYMMETRIC (SYMMETRIC)
    ) u_out_clip (
        .i_d    (w_acc_clipped),
        .o_q    (w_out_clipped),
        .o_clip (w_out_clip)
    );

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_acc_load   = 1'b0;
        w_frame_done = 1'b0;
        if (w_in_acc) begin
            w_acc_load   = !sif.in_last;
            w_frame_done = sif.in_last;
        end
        case (r_state)
            IDLE, ACCUM: begin
                if (w_in_acc)
                    w_state_nxt = sif.in_last ? HOLD : ACCUM;
            end
            HOLD: begin
                // In HOLD a sample can only be taken when out_ready is high,
                // so an accepted sample implies the result left too.
                if (w_in_acc)
                    w_state_nxt = sif.in_last ? HOLD : ACCUM;
                else if (w_out_acc)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_flag      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc_load) begin
                r_acc  <= w_acc_clipped;
                r_flag <= r_flag | w_acc_clip;
            end else if (w_frame_done) begin
                r_acc  <= '0;
                r_flag <= 1'b0;
            end
            // Output register stage: a new frame total overrides a result
            // leaving in the same cycle.
            if (w_frame_done) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_out_clipped;
                r_out_sat   <= r_flag | w_acc_clip | w_out_clip;
            end else if (w_out_acc) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign sif.out_valid = r_out_valid;
    assign sif.out_data  = r_out_data;
    assign sif.out_sat   = r_out_sat;

`ifdef SAT_ACCUM_STATS_EN
    logic [CNT_W-1:0] r_sat_cnt;

    always_ff @(posedge clk) begin
        if (!rst_b)
            r_sat_cnt <= '0;
        else if (w_out_acc && r_out_sat)
            r_sat_cnt <= r_sat_cnt + 1'b1;
    end

    assign sif.sat_count = r_sat_cnt;
`else
    assign sif.sat_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_sat_accum_bs.sv
// ---------------------------------------------------------------------------
// tb_sat_accum_bs
// Scoreboard bench for sat_accum_bs: expected frame results are queued when
// the last sample is issued; monitors pop and compare on every accepted
// result. A second instance covers SYMMETRIC=0.
// ---------------------------------------------------------------------------
module tb_sat_accum_bs;

`ifdef SAT_ACCUM_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    typedef struct {
        logic signed [3:0] d;
        logic              s;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b;
    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t q0[$];

    always #5 clk = ~clk;

    sat_accum_bs_if #(.IN_W(8), .OUT_W(4), .CNT_W(16)) bif ();
    sat_accum_bs_if #(.IN_W(8), .OUT_W(4), .CNT_W(16)) bif0 ();

    sat_accum_bs #(
        .IN_W(8), .OUT_W(4), .ACC_W(12), .SYMMETRIC(1'b1), .CNT_W(16)
    ) u_dut (
        .clk   (clk),
        .rst_b (rst_b),
        .sif   (bif)
    );

    sat_accum_bs #(
        .IN_W(8), .OUT_W(4), .ACC_W(12), .SYMMETRIC(1'b0), .CNT_W(16)
    ) u_dut0 (
        .clk   (clk),
        .rst_b (rst_b),
        .sif   (bif0)
    );

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Result monitors: every accepted result is matched to the queue head.
    always @(negedge clk) begin
        if (bif.out_valid && bif.out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", longint'(bif.out_data), longint'(e.d));
                chk("out_sat", longint'(bif.out_sat), longint'(e.s));
            end
        end
    end

    always @(negedge clk) begin
        if (bif0.out_valid && bif0.out_ready) begin
            if (q0.size() == 0) begin
                chk("sym0_unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("sym0_out_data", longint'(bif0.out_data), longint'(e.d));
                chk("sym0_out_sat", longint'(bif0.out_sat), longint'(e.s));
            end
        end
    end

    // Present one sample from posedge+1 until accepted; queue the expected
    // result when it closes a frame. Returns at posedge+1 after acceptance.
    task automatic send(input logic signed [7:0] d, input logic last,
                        input logic signed [3:0] ed, input logic es);
        logic ok;
        bif.in_valid = 1'b1;
        bif.in_data  = d;
        bif.in_last  = last;
        if (last) q.push_back('{d: ed, s: es});
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bif.in_ready;
            @(posedge clk);
        end
        if (!ok) chk("in_ready_timeout", 0, 1);
        #1;
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"},  longint'(bif.in_ready), 1);
        chk({tag, "_out_valid"}, longint'(bif.out_valid), 0);
        chk({tag, "_out_data"},  longint'(bif.out_data), 0);
        chk({tag, "_out_sat"},   longint'(bif.out_sat), 0);
        chk({tag, "_sat_count"}, longint'(bif.sat_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.in_valid   = 1'b0;
        bif.in_data    = '0;
        bif.in_last    = 1'b0;
        bif.out_ready  = 1'b1;
        bif0.in_valid  = 1'b0;
        bif0.in_data   = '0;
        bif0.in_last   = 1'b0;
        bif0.out_ready = 1'b1;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        @(negedge clk);
        chk_reset_values("reset");
        @(posedge clk);
        #1;

        // Two's-complement instance: -18 clips to -8.
        bif0.in_valid = 1'b1;
        bif0.in_data  = -8'sd18;
        bif0.in_last  = 1'b1;
        q0.push_back('{d: -4'sd8, s: 1'b1});
        @(posedge clk);
        #1;
        bif0.in_valid = 1'b0;
        bif0.in_last  = 1'b0;

        // Single-sample frame and simple output clipping.
        send(-18, 1'b1, -7, 1'b1);
        send(4, 1'b0, 0, 1'b0);
        send(4, 1'b1, 7, 1'b1);
        send(-4, 1'b1, -4, 1'b0);

        // Accumulator saturation: 2047 sticky, then 1919 -> 7.
        repeat (20) send(127, 1'b0, 0, 1'b0);
        send(-128, 1'b1, 7, 1'b1);
        repeat (20) send(-128, 1'b0, 0, 1'b0);
        send(127, 1'b1, -7, 1'b1);
        drain();
        chk("sat_count_before_reset", longint'(bif.sat_count), 4 * STATS);

        // Latency and backpressure.
        bif.out_ready = 1'b0;
        send(3, 1'b0, 0, 1'b0);
        send(2, 1'b0, 0, 1'b0);
        chk("valid_before_last", longint'(bif.out_valid), 0);
        send(1, 1'b1, 6, 1'b0);
        @(negedge clk);
        chk("latency_out_valid", longint'(bif.out_valid), 1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_in_ready", longint'(bif.in_ready), 0);
            chk("stall_out_valid", longint'(bif.out_valid), 1);
            chk("stall_out_data", longint'(bif.out_data), 6);
        end
        @(posedge clk);
        #1;
        bif.out_ready = 1'b1;
        send(-4, 1'b1, -4, 1'b0);
        @(negedge clk);
        chk("overlap_out_valid", longint'(bif.out_valid), 1);
        chk("overlap_out_data", longint'(bif.out_data), -4);
        drain();

        // Reset mid-frame discards the partial sum.
        send(5, 1'b0, 0, 1'b0);
        send(5, 1'b0, 0, 1'b0);
        rst_b = 1'b0;
        @(posedge clk);
        #1 rst_b = 1'b1;
        @(negedge clk);
        chk_reset_values("midframe_reset");
        repeat (2) begin
            @(negedge clk);
            chk("no_discarded_result", longint'(bif.out_valid), 0);
        end
        @(posedge clk);
        #1;
        send(2, 1'b1, 2, 1'b0);
        repeat (3) send(-18, 1'b1, -7, 1'b1);
        drain();
        chk("sat_count_after_reset", longint'(bif.sat_count), 3 * STATS);
        chk("sym0_pending", q0.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
